divmmc_memctl: RTL and testbench
================================

Name: divmmc_memctl

Overview:
- Sits directly downstream of the DivMMC paging unit.
- Consumes its map/ram/page outputs together with the CPU bus and turns each CPU memory cycle into one sequenced access on the external 512 KB SRAM.
- Translates CPU addresses to physical addresses, enforces DivMMC write protection, inserts CPU wait states and returns read data.

Parameters:
- DIVROM, default 19'h1E000, physical base of the 8 KB DivMMC ROM.
- DIVRAM, default 19'h20000, physical base of the 16 x 8 KB DivMMC RAM pages.
- WAITS, default 1, number of ce ticks the SRAM strobe is held (1..7).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ce  in  1  CPU clock enable; all state advances only on ce
- mreq  in  1  CPU memory request, active low
- rd  in  1  CPU read, active low
- wr  in  1  CPU write, active low
- a  in  16  CPU address
- d  in  8  CPU write data
- map  in  1  DivMMC memory paged into 0000-3FFF
- ram  in  1  MAPRAM mode active
- page  in  4  DivMMC RAM page (already forced to 3 for 0000-1FFF when ram)
- q  out  8  read data to CPU
- waitn  out  1  CPU WAIT, active low
- memA  out  19  SRAM address
- memD  out  8  SRAM write data
- memQ  in  8  SRAM read data
- memRd  out  1  SRAM read strobe, active high
- memWr  out  1  SRAM write strobe, active high
- wprot  out  1  high when the current/last access was a write-protected write

Behaviour:
- Reset (reset low at a clock edge, regardless of ce or state): state IDLE, counter 0, memRd=0, memWr=0, memA=0, memD=0, q=8'hFF, waitn=1, wprot=0. A reset mid-access kills the strobe at that same edge.
- Address translation, evaluated at capture:
  - map=0: phys = {3'b000, a}.
  - map=1, a[15:13]=000: ram=1 gives DIVRAM + {page, a[12:0]}; ram=0 gives DIVROM + a[12:0].
  - map=1, a[15:13]=001: DIVRAM + {page, a[12:0]}.
  - map=1, a>=4000: phys = {3'b000, a}.
  - Addition is 19-bit and wraps modulo 2^19.
- Write protection is asserted for a write when any of these hold:
  - map=0 and a<4000 (Spectrum ROM).
  - map=1, a[15:13]=000.
  - map=1, a[15:13]=001, ram=1, page=3.
- IDLE:
  - Capture occurs on ce with mreq=0 and (rd=0 or wr=0).
  - At capture: latch memA=phys, memD=d, direction, wprot; drive waitn=0; go to SETUP.
  - mreq=0 with rd=wr=1 (refresh) is ignored.
  - If rd and wr are both low, the access is treated as a write.
- SETUP: on next ce, assert memRd (read), or memWr (write and not wprot); load counter=WAITS; go to STROBE. A protected write goes to STROBE with no strobe asserted.
- STROBE:
  - Each ce decrements the counter.
  - When the counter reaches 0 on a ce: for a read, q<=memQ; deassert memRd and memWr; waitn=1; go to DONE.
  - Minimum access is 1 (capture) + 1 + WAITS ce ticks.
- DONE: stay until a ce with mreq=1, then go to IDLE. Re-entry into capture cannot occur in the same ce as leaving DONE.
- An access whose mreq deasserts mid-sequence still completes; DONE then exits on the next ce.
- memA and memD hold their values between accesses. q holds the last read value. wprot holds until the next capture.
- Without ce, no outputs change except through reset.

Test Plan:
- Reset: pulse reset low for 1 clock mid-STROBE of a write -> memWr=0 on that edge, waitn=1, q=FF, state IDLE.
- Unmapped read: map=0, a=4123, rd=0, memQ=5A, WAITS=1 -> memA=04123, memRd high for exactly 1 ce, waitn low 2 ce ticks, q=5A.
- DivMMC ROM read: map=1, ram=0, a=0066 -> memA=1E066. Write to a=0066 -> wprot=1, memWr never asserted.
- DivMMC RAM write: map=1, ram=0, page=5, a=2ABC, d=C3 -> memA=2AABC, memD=C3, memWr for WAITS ce ticks. Same with ram=1, page=3 -> wprot=1, no memWr.
- Refresh and back-to-back: mreq=0, rd=wr=1 -> no strobe. Two reads with mreq high for one ce between -> two separate accesses, second captured only after DONE->IDLE.
- Wrap: set DIVRAM=19'h7E000, page=1, a=2000 -> memA=00000 (modulo 2^19).

Source files
------------

// File: rtl/divmmc_memctl_if.sv
// +----------------------------------------------------------------------------+
// | divmmc_memctl_if : CPU, paging and SRAM bus bundle for divmmc_memctl       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface divmmc_memctl_if;
    logic        ce;
    logic        mreq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        map;
    logic        ram;
    logic [3:0]  page;
    logic [7:0]  q;
    logic        waitn;
    logic [18:0] memA;
    logic [7:0]  memD;
    logic [7:0]  memQ;
    logic        memRd;
    logic        memWr;
    logic        wprot;

    modport master (
        output ce, mreq, rd, wr, a, d, map, ram, page, memQ,
        input  q, waitn, memA, memD, memRd, memWr, wprot
    );

    modport slave (
        input  ce, mreq, rd, wr, a, d, map, ram, page, memQ,
        output q, waitn, memA, memD, memRd, memWr, wprot
    );
endinterface

`default_nettype wire

// File: rtl/divmmc_memctl.sv
// +----------------------------------------------------------------------------+
// | divmmc_memctl : sequences one external SRAM access per CPU memory cycle    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module divmmc_memctl #(
    parameter logic [18:0] DIVROM = 19'h1E000,
    parameter logic [18:0] DIVRAM = 19'h20000,
    parameter int unsigned WAITS  = 1
) (
    input  wire logic      clock_i,
    input  wire logic      reset_i,
    divmmc_memctl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] WAITS_C = 3'(WAITS);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [18:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_d_q, mem_d_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  q_q, q_d;
    logic        waitn_q, waitn_d;
    logic        wprot_q, wprot_d;
    logic        is_wr_q, is_wr_d;

    logic [18:0] phys;
    logic        prot;
    logic        req;

    // RAM pages are 8 KB each, stacked above DIVRAM; sums wrap at 19 bits.
    always_comb begin
        if (!bus.map || bus.a[15:14] != 2'b00) begin
            phys = {3'b000, bus.a};
        end else if (bus.a[13] || bus.ram) begin
            phys = DIVRAM + {2'b00, bus.page, bus.a[12:0]};
        end else begin
            phys = DIVROM + {6'b000000, bus.a[12:0]};
        end
    end

    always_comb begin
        if (bus.map) begin
            prot = (bus.a[15:13] == 3'b000) ||
                   (bus.a[15:13] == 3'b001 && bus.ram && bus.page == 4'd3);
        end else begin
            prot = (bus.a[15:14] == 2'b00);
        end
    end

    assign req = !bus.mreq && (!bus.rd || !bus.wr);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        q_d      = q_q;
        waitn_d  = waitn_q;
        wprot_d  = wprot_q;
        is_wr_d  = is_wr_q;
        if (bus.ce) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        mem_a_d = phys;
                        mem_d_d = bus.d;
                        is_wr_d = !bus.wr;
                        wprot_d = !bus.wr && prot;
                        waitn_d = 1'b0;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    mem_rd_d = !is_wr_q;
                    mem_wr_d = is_wr_q && !wprot_q;
                    cnt_d    = WAITS_C;
                    state_d  = STROBE;
                end
                STROBE: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (!is_wr_q) begin
                            q_d = bus.memQ;
                        end
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        waitn_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (bus.mreq) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            mem_a_q  <= 19'd0;
            mem_d_q  <= 8'd0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            q_q      <= 8'hFF;
            waitn_q  <= 1'b1;
            wprot_q  <= 1'b0;
            is_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            q_q      <= q_d;
            waitn_q  <= waitn_d;
            wprot_q  <= wprot_d;
            is_wr_q  <= is_wr_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.waitn = waitn_q;
    assign bus.memA  = mem_a_q;
    assign bus.memD  = mem_d_q;
    assign bus.memRd = mem_rd_q;
    assign bus.memWr = mem_wr_q;
    assign bus.wprot = wprot_q;

endmodule

`default_nettype wire

// File: tb/tb_divmmc_memctl.sv
// +----------------------------------------------------------------------------+
// | tb_divmmc_memctl : directed and randomized checks against a memory model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_divmmc_memctl;

    localparam int          W      = 2;
    localparam logic [18:0] ROM_B  = 19'h1E000;
    localparam logic [18:0] RAM_B  = 19'h20000;
    localparam logic [18:0] RAM_B2 = 19'h7E000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  m_q  = 8'hFF;
    logic [18:0] m_a  = 19'd0;
    logic [18:0] m_a2 = 19'd0;
    logic [7:0]  m_d  = 8'd0;

    divmmc_memctl_if bus ();
    divmmc_memctl_if bus2 ();

    // Second instance sees identical CPU traffic but a RAM base near the top of memory.
    assign bus2.ce   = bus.ce;
    assign bus2.mreq = bus.mreq;
    assign bus2.rd   = bus.rd;
    assign bus2.wr   = bus.wr;
    assign bus2.a    = bus.a;
    assign bus2.d    = bus.d;
    assign bus2.map  = bus.map;
    assign bus2.ram  = bus.ram;
    assign bus2.page = bus.page;
    assign bus2.memQ = bus.memQ;

    divmmc_memctl #(.DIVROM(ROM_B), .DIVRAM(RAM_B), .WAITS(W)) u_dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus.slave)
    );

    divmmc_memctl #(.DIVROM(ROM_B), .DIVRAM(RAM_B2), .WAITS(W)) u_wrap (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] mphys(input int divrom, input int divram, input bit m,
                                          input bit r, input int pg, input int addr);
        int p;
        if (!m || addr >= 'h4000)        p = addr;
        else if (addr < 'h2000 && !r)    p = divrom + addr % 'h2000;
        else                             p = divram + pg * 'h2000 + addr % 'h2000;
        return 19'(p % 'h80000);
    endfunction

    function automatic bit mprot(input bit m, input bit r, input int pg, input int addr);
        if (!m)            return addr < 'h4000;
        if (addr < 'h2000) return 1'b1;
        if (addr < 'h4000) return r && pg == 3;
        return 1'b0;
    endfunction

    task automatic tick(output bit hit);
        @(negedge clk);
        bus.ce = ($urandom_range(0, 2) != 0);
        hit    = bus.ce;
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        bit hit;
        bus.mreq = 1'b1;
        bus.rd   = 1'b1;
        bus.wr   = 1'b1;
        hit      = 1'b0;
        for (int g = 0; g < 100 && !hit; g++) tick(hit);
    endtask

    task automatic access(input bit do_rd, input bit do_wr, input logic [15:0] addr,
                          input logic [7:0] dat, input bit m, input bit r,
                          input logic [3:0] pg, input logic [7:0] mq,
                          input bit drop, input int linger);
        bit hit, started, done, is_read, exp_prot;
        int rd_n, wr_n, wt_n, seen;
        rd_n = 0; wr_n = 0; wt_n = 0; seen = 0;
        started = 1'b0; done = 1'b0;
        bus.mreq = 1'b0;
        bus.rd   = !do_rd;
        bus.wr   = !do_wr;
        bus.a    = addr;
        bus.d    = dat;
        bus.map  = m;
        bus.ram  = r;
        bus.page = pg;
        bus.memQ = mq;
        is_read  = !do_wr;
        exp_prot = do_wr && mprot(m, r, int'(pg), int'(addr));
        for (int g = 0; g < 400 && !done; g++) begin
            tick(hit);
            if (hit) begin
                if (bus.memRd) rd_n++;
                if (bus.memWr) wr_n++;
                if (!bus.waitn) begin
                    wt_n++;
                    started = 1'b1;
                    if (drop) bus.mreq = 1'b1;
                end else if (started) begin
                    done = 1'b1;
                end
            end
        end
        m_a  = mphys(int'(ROM_B), int'(RAM_B), m, r, int'(pg), int'(addr));
        m_a2 = mphys(int'(ROM_B), int'(RAM_B2), m, r, int'(pg), int'(addr));
        m_d  = dat;
        if (is_read) m_q = mq;
        chk("access_done", done, 1'b1);
        chk("memA", bus.memA, m_a);
        chk("memA_wrapdut", bus2.memA, m_a2);
        chk("memD", bus.memD, m_d);
        chk("q", bus.q, m_q);
        chk("wprot", bus.wprot, exp_prot);
        chk("memRd_ticks", rd_n, is_read ? W : 0);
        chk("memWr_ticks", wr_n, (!is_read && !exp_prot) ? W : 0);
        chk("wait_ticks", wt_n, W + 1);
        for (int g = 0; g < 100 && seen < linger; g++) begin
            tick(hit);
            if (hit) begin
                seen++;
                chk("linger_strobe", bus.memRd | bus.memWr, 1'b0);
                chk("linger_waitn", bus.waitn, 1'b1);
            end
        end
        release_bus();
    endtask

    task automatic refresh(input int n);
        bit hit;
        int seen;
        seen     = 0;
        bus.mreq = 1'b0;
        bus.rd   = 1'b1;
        bus.wr   = 1'b1;
        for (int g = 0; g < 100 && seen < n; g++) begin
            tick(hit);
            if (hit) begin
                seen++;
                chk("refresh_strobe", bus.memRd | bus.memWr, 1'b0);
                chk("refresh_waitn", bus.waitn, 1'b1);
            end
        end
        chk("refresh_memA", bus.memA, m_a);
        bus.mreq = 1'b1;
    endtask

    initial begin
        bit          hit;
        int          kind;
        logic [15:0] ad;

        bus.ce = 1'b0; bus.mreq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
        bus.a = 16'h0; bus.d = 8'h0; bus.map = 1'b0; bus.ram = 1'b0;
        bus.page = 4'h0; bus.memQ = 8'h0;

        repeat (3) tick(hit);
        chk("rst_memRd", bus.memRd, 1'b0);
        chk("rst_memWr", bus.memWr, 1'b0);
        chk("rst_memA", bus.memA, 19'h0);
        chk("rst_memD", bus.memD, 8'h0);
        chk("rst_q", bus.q, 8'hFF);
        chk("rst_waitn", bus.waitn, 1'b1);
        chk("rst_wprot", bus.wprot, 1'b0);
        rst_n = 1'b1;

        access(1, 0, 16'h4123, 8'h00, 0, 0, 4'h0, 8'h5A, 0, 0);
        chk("unmapped_read_addr", bus.memA, 19'h04123);
        access(1, 0, 16'h0066, 8'h00, 1, 0, 4'h0, 8'h11, 0, 0);
        chk("rom_read_addr", bus.memA, 19'h1E066);
        access(0, 1, 16'h0066, 8'h77, 1, 0, 4'h0, 8'h22, 0, 0);
        access(0, 1, 16'h2ABC, 8'hC3, 1, 0, 4'h5, 8'h00, 0, 0);
        chk("ram_write_addr", bus.memA, 19'h2AABC);
        access(0, 1, 16'h2ABC, 8'hC3, 1, 1, 4'h3, 8'h00, 0, 0);
        access(1, 0, 16'h2000, 8'h00, 1, 0, 4'h1, 8'h3C, 0, 0);
        chk("wrap_zero", bus2.memA, 19'h00000);
        refresh(5);
        access(1, 1, 16'h8000, 8'h9E, 0, 0, 4'h0, 8'h44, 0, 0);
        access(1, 0, 16'hC000, 8'h00, 0, 0, 4'h0, 8'hA1, 0, 3);
        access(1, 0, 16'hC001, 8'h00, 0, 0, 4'h0, 8'hB2, 0, 0);
        access(1, 0, 16'h5555, 8'h00, 1, 1, 4'h7, 8'h6D, 1, 0);

        // Kill a write while its strobe is up; ce is held low to show reset ignores it.
        bus.mreq = 1'b0; bus.rd = 1'b1; bus.wr = 1'b0; bus.a = 16'h2ABC;
        bus.d = 8'hC3; bus.map = 1'b1; bus.ram = 1'b0; bus.page = 4'h5;
        hit = 1'b0;
        for (int g = 0; g < 100 && !bus.memWr; g++) tick(hit);
        chk("rst_pre_memWr", bus.memWr, 1'b1);
        @(negedge clk);
        bus.ce = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_memWr", bus.memWr, 1'b0);
        chk("midrst_waitn", bus.waitn, 1'b1);
        chk("midrst_q", bus.q, 8'hFF);
        chk("midrst_memA", bus.memA, 19'h0);
        chk("midrst_wprot", bus.wprot, 1'b0);
        rst_n = 1'b1;
        bus.mreq = 1'b1; bus.wr = 1'b1;
        m_q = 8'hFF; m_a = 19'h0; m_a2 = 19'h0; m_d = 8'h0;
        access(1, 0, 16'h7F00, 8'h00, 0, 0, 4'h0, 8'hE7, 0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            ad   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 16'h3FFF)) : 16'($urandom);
            access(kind != 1, kind != 0, ad, 8'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
